fft_output_buffer: RTL and testbench

Frame buffer on the output side of the pipelined FFT. It captures one frame of `FFT_POINTS` results from the FFT output stream (`data_out_valid` / `data_out_real` / `data_out_imag`). It optionally undoes bit-reversed ordering and then drains the frame in natural bin order over a valid/ready handshake to the downstream consumer (host interface or magnitude unit).

---
 rtl/fft_output_buffer.sv | 132 +++++++++++++
 tb/tb_fft_output_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_buffer.sv
// FFT output frame buffer: captures one frame, optionally undoes
// bit-reversed order, and drains it in natural bin order over valid/ready.
module fft_output_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FFT_POINTS  = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  frame_full,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    CAPTURE,
    LOAD,
    DRAIN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(FFT_POINTS - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   wr_cnt_q;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q;
  logic [ADDR_WIDTH-1:0]   rd_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    out_valid_q;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   out_real_q;
  logic [DATA_WIDTH-1:0]   out_imag_q;
  logic                    wr_en;
  logic [2*DATA_WIDTH-1:0] mem_q [FFT_POINTS];

  function automatic logic [ADDR_WIDTH-1:0] bitrev(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = a[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

  always_comb begin
    wr_addr = (BIT_REVERSE != 0) ? bitrev(wr_cnt_q) : wr_cnt_q;
    wr_en   = (state_q == CAPTURE) && in_valid && !clear;
    rd_nxt  = rd_cnt_q + 1'b1;
  end

  // Sample storage carries no reset; only CAPTURE may write it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {in_real, in_imag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CAPTURE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else if (clear) begin
      state_q     <= CAPTURE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (in_valid) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          {out_real_q, out_imag_q} <= mem_q[0];
          rd_cnt_q    <= '0;
          out_valid_q <= 1'b1;
          state_q     <= DRAIN;
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
          if (out_valid_q && out_ready) begin
            if (rd_cnt_q == LAST) begin
              out_valid_q <= 1'b0;
              rd_cnt_q    <= '0;
              state_q     <= CAPTURE;
            end else begin
              {out_real_q, out_imag_q} <= mem_q[rd_nxt];
              rd_cnt_q <= rd_nxt;
            end
          end
        end
        default: state_q <= CAPTURE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign out_index  = rd_cnt_q;
  assign out_last   = out_valid_q && (rd_cnt_q == LAST);
  assign frame_full = (state_q != CAPTURE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_output_buffer.sv
// Directed bench: a bit-reversing and a natural-order buffer share
// stimulus; each drained bin is compared against a hand-built table.
module tb_fft_output_buffer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NP = 8;
  localparam int REV [NP] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          out_ready = 1'b0;

  logic          r_ov, r_last, r_ff, r_of;
  logic [DW-1:0] r_re, r_im;
  logic [AW-1:0] r_idx;
  logic          n_ov, n_last, n_ff, n_of;
  logic [DW-1:0] n_re, n_im;
  logic [AW-1:0] n_idx;

  int checks = 0;
  int failures = 0;

  fft_output_buffer #(
    .DATA_WIDTH(DW), .FFT_POINTS(NP),
    .ADDR_WIDTH(AW), .BIT_REVERSE(1)
  ) u_rev (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_valid(r_ov), .out_ready(out_ready),
    .out_real(r_re), .out_imag(r_im), .out_index(r_idx),
    .out_last(r_last), .frame_full(r_ff), .overflow(r_of)
  );

  fft_output_buffer #(
    .DATA_WIDTH(DW), .FFT_POINTS(NP),
    .ADDR_WIDTH(AW), .BIT_REVERSE(0)
  ) u_nat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_valid(n_ov), .out_ready(out_ready),
    .out_real(n_re), .out_imag(n_im), .out_index(n_idx),
    .out_last(n_last), .frame_full(n_ff), .overflow(n_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic ff,
                           input logic of);
    chk({tag, "_rff"}, r_ff, ff);
    chk({tag, "_nff"}, n_ff, ff);
    chk({tag, "_rof"}, r_of, of);
    chk({tag, "_nof"}, n_of, of);
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int k = 0; k < NP; k++) begin
      in_valid = 1'b1;
      in_real  = DW'(base + k);
      in_imag  = DW'(100 + base + k);
      step();
      in_valid = 1'b0;
      chk("cap_rff", r_ff, k == NP - 1);
      chk("cap_nff", n_ff, k == NP - 1);
      if (gaps && k < NP - 1) begin
        int g;
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step();
      end
    end
    chk("load_rov", r_ov, 1'b0);
    chk("load_nov", n_ov, 1'b0);
  endtask

  task automatic drain(input int base, input bit bp,
                       input int stop, input logic [7:0] inj);
    int i, c;
    logic r;
    i = 0;
    c = 0;
    step();
    chk("first_rov", r_ov, 1'b1);
    chk("first_nov", n_ov, 1'b1);
    while (i < stop && c < 64) begin
      chk("rv_val", r_ov, 1'b1);
      chk("rv_idx", r_idx, i);
      chk("rv_re", r_re, base + REV[i]);
      chk("rv_im", r_im, 100 + base + REV[i]);
      chk("rv_last", r_last, i == NP - 1);
      chk("nt_val", n_ov, 1'b1);
      chk("nt_idx", n_idx, i);
      chk("nt_re", n_re, base + i);
      chk("nt_im", n_im, 100 + base + i);
      chk("nt_last", n_last, i == NP - 1);
      r = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      out_ready = r;
      in_valid  = r && inj[i];
      in_real   = 16'd55;
      in_imag   = 16'd155;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (r) i++;
      c++;
    end
    chk("drain_bound", c < 64, 1'b1);
    if (stop == NP) begin
      chk("end_rov", r_ov, 1'b0);
      chk("end_nov", n_ov, 1'b0);
      chk("end_rff", r_ff, 1'b0);
      chk("end_nlast", n_last, 1'b0);
    end
  endtask

  initial begin
    #2;
    chk("rst_rov", r_ov, 1'b0);
    chk("rst_rlast", r_last, 1'b0);
    chk("rst_re", r_re, 0);
    chk("rst_idx", r_idx, 0);
    chk_flags("rst", 1'b0, 1'b0);
    #5 rst_n = 1'b1;
    step();

    // 1: reordering, back-to-back
    send_frame(0, 1'b0);
    drain(0, 1'b0, NP, 8'h00);
    chk_flags("s1", 1'b0, 1'b0);

    // 2: backpressure 1,0,0,1
    send_frame(0, 1'b0);
    drain(0, 1'b1, NP, 8'h00);
    chk_flags("s2", 1'b0, 1'b0);

    // 3: overflow mid-drain and on the last handshake
    send_frame(0, 1'b0);
    drain(0, 1'b0, NP, 8'h88);
    chk_flags("s3a", 1'b0, 1'b1);
    send_frame(20, 1'b0);
    drain(20, 1'b0, NP, 8'h00);
    chk_flags("s3b", 1'b0, 1'b1);

    // 4: clear mid-capture with a simultaneous sample
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_real  = DW'(k);
      in_imag  = DW'(100 + k);
      step();
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_real  = 16'd99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_flags("s4clr", 1'b0, 1'b0);
    send_frame(10, 1'b0);
    drain(10, 1'b0, NP, 8'h00);
    chk_flags("s4", 1'b0, 1'b0);

    // 5: asynchronous reset after bin 3 accepted
    send_frame(0, 1'b0);
    drain(0, 1'b0, 4, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rov", r_ov, 1'b0);
    chk("s5_nov", n_ov, 1'b0);
    chk("s5_idx", r_idx, 0);
    chk("s5_re", r_re, 0);
    chk("s5_im", n_im, 0);
    chk("s5_last", r_last, 1'b0);
    chk_flags("s5", 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    send_frame(30, 1'b0);
    drain(30, 1'b0, NP, 8'h00);

    // 6: gapped input
    send_frame(0, 1'b1);
    drain(0, 1'b0, NP, 8'h00);
    chk_flags("s6", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
